// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyph patterns, reader FSM states.
// Used by both the display writer and the word reader.
package seg7_pkg;

    localparam int unsigned GLYPHS_PER_WORD = 4;
    localparam int unsigned WORD_W          = 4 * GLYPHS_PER_WORD;

    // Bit order is {g,f,e,d,c,b,a}; a 0 bit means the segment is lit.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_LUT [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    typedef enum logic [1:0] {HUNT, G1, G2, G3} word_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational active-low segment pattern to hex glyph decoder.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic       blank,
    output logic [3:0] code
);

    always_comb begin
        valid = 1'b0;
        blank = (pattern == SEG_BLANK);
        code  = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_LUT[i]) begin
                valid = 1'b1;
                code  = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_word_reader.sv
// Decodes a 7-segment bus into glyphs and aligns them into 4-glyph words.
// Optional SEG7_MATCH_COUNT_EN adds saturating match_cnt / miss_cnt outputs.
module seg7_word_reader
    import seg7_pkg::*;
#(
    parameter logic [15:0] EXPECT         = 16'hDE10,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seg_valid,
    input  logic [6:0]  seg_in,
    output logic        glyph_valid,
    output logic [3:0]  glyph_code,
    output logic        glyph_err,
    output logic        word_valid,
    output logic [15:0] word,
    output logic        match
`ifdef SEG7_MATCH_COUNT_EN
    ,
    output logic [15:0] match_cnt,
    output logic [15:0] miss_cnt
`endif
);

    logic [6:0]  norm_seg;
    logic        dec_valid;
    logic        dec_blank;
    logic [3:0]  dec_code;

    word_state_e state_q, state_d;
    logic [11:0] part_q, part_d;
    logic        glyph_valid_d, glyph_err_d, word_valid_d, match_d;
    logic [3:0]  glyph_code_d;
    logic [15:0] word_d;

    assign norm_seg = SEG_ACTIVE_LOW ? seg_in : ~seg_in;

    seg7_glyph_decode u_decode (
        .pattern (norm_seg),
        .valid   (dec_valid),
        .blank   (dec_blank),
        .code    (dec_code)
    );

    always_comb begin
        state_d       = state_q;
        part_d        = part_q;
        glyph_valid_d = 1'b0;
        glyph_err_d   = 1'b0;
        word_valid_d  = 1'b0;
        match_d       = 1'b0;
        glyph_code_d  = glyph_code;
        word_d        = word;
        // Blank samples are ignored entirely, like seg_valid=0.
        if (seg_valid && !dec_blank) begin
            if (dec_valid) begin
                glyph_valid_d = 1'b1;
                glyph_code_d  = dec_code;
                case (state_q)
                    HUNT: begin
                        if (dec_code == EXPECT[15:12]) begin
                            part_d  = {8'h00, dec_code};
                            state_d = G1;
                        end
                    end
                    G1: begin
                        part_d  = {part_q[7:0], dec_code};
                        state_d = G2;
                    end
                    G2: begin
                        part_d  = {part_q[7:0], dec_code};
                        state_d = G3;
                    end
                    G3: begin
                        word_valid_d = 1'b1;
                        word_d       = {part_q, dec_code};
                        match_d      = ({part_q, dec_code} == EXPECT);
                        state_d      = HUNT;
                    end
                    default: state_d = HUNT;
                endcase
            end else begin
                glyph_err_d = 1'b1;
                part_d      = '0;
                state_d     = HUNT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            part_q      <= '0;
            glyph_valid <= 1'b0;
            glyph_code  <= 4'h0;
            glyph_err   <= 1'b0;
            word_valid  <= 1'b0;
            word        <= '0;
            match       <= 1'b0;
        end else begin
            state_q     <= state_d;
            part_q      <= part_d;
            glyph_valid <= glyph_valid_d;
            glyph_code  <= glyph_code_d;
            glyph_err   <= glyph_err_d;
            word_valid  <= word_valid_d;
            word        <= word_d;
            match       <= match_d;
        end
    end

`ifdef SEG7_MATCH_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else if (word_valid_d) begin
            if (match_d && (match_cnt != 16'hFFFF)) match_cnt <= match_cnt + 16'd1;
            if (!match_d && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_word_reader.sv
// Scoreboard bench for seg7_word_reader: a reference model pushes expected
// per-cycle outputs when a sample is driven; they are popped after the edge.
module tb_seg7_word_reader;

    localparam logic [15:0] EXP   = 16'hDE10;
    localparam logic [6:0]  BLANK = 7'b1111111;
    localparam logic [6:0]  BAD   = 7'b0110110;

    logic        clk = 1'b0;
    logic        rst;
    logic        seg_valid;
    logic [6:0]  seg_in;
    logic        glyph_valid, glyph_err, word_valid, match;
    logic [3:0]  glyph_code;
    logic [15:0] word;
`ifdef SEG7_MATCH_COUNT_EN
    logic [15:0] match_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    seg7_word_reader dut (
        .clk         (clk),
        .rst         (rst),
        .seg_valid   (seg_valid),
        .seg_in      (seg_in),
        .glyph_valid (glyph_valid),
        .glyph_code  (glyph_code),
        .glyph_err   (glyph_err),
        .word_valid  (word_valid),
        .word        (word),
        .match       (match)
`ifdef SEG7_MATCH_COUNT_EN
        ,
        .match_cnt   (match_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    typedef struct packed {
        logic        gv;
        logic [3:0]  code;
        logic        ge;
        logic        wv;
        logic [15:0] word;
        logic        m;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wv_seen;

    int          m_state;
    logic [15:0] m_acc, m_word;
    logic [3:0]  m_code;
    int          m_hit, m_miss;

    function automatic logic [6:0] pat(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_acc   = '0;
        m_word  = '0;
        m_code  = '0;
        m_hit   = 0;
        m_miss  = 0;
    endtask

    function automatic exp_t model_step(input logic v, input logic [6:0] p);
        exp_t e;
        logic found = 1'b0;
        logic [3:0] c = 4'h0;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            if (p == pat(4'(i))) begin
                found = 1'b1;
                c     = 4'(i);
            end
        end
        if (v && p != BLANK) begin
            if (found) begin
                e.gv   = 1'b1;
                m_code = c;
                if (m_state == 0) begin
                    if (c == EXP[15:12]) begin
                        m_acc   = {12'h000, c};
                        m_state = 1;
                    end
                end else begin
                    m_acc = {m_acc[11:0], c};
                    if (m_state == 3) begin
                        e.wv    = 1'b1;
                        m_word  = m_acc;
                        e.m     = (m_acc == EXP);
                        if (e.m) m_hit++;
                        else     m_miss++;
                        m_state = 0;
                    end else begin
                        m_state++;
                    end
                end
            end else begin
                e.ge    = 1'b1;
                m_state = 0;
            end
        end
        e.code = m_code;
        e.word = m_word;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [6:0] p);
        exp_t e;
        @(negedge clk);
        seg_valid = v;
        seg_in    = p;
        sb.push_back(model_step(v, p));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("glyph_valid", 32'(glyph_valid), 32'(e.gv));
        check_eq("glyph_code", 32'(glyph_code), 32'(e.code));
        check_eq("glyph_err", 32'(glyph_err), 32'(e.ge));
        check_eq("word_valid", 32'(word_valid), 32'(e.wv));
        check_eq("word", 32'(word), 32'(e.word));
        check_eq("match", 32'(match), 32'(e.m));
        if (word_valid) wv_seen++;
    endtask

    task automatic glyph(input logic [3:0] n);
        drive(1'b1, pat(n));
    endtask

    task automatic word4(input logic [15:0] w);
        glyph(w[15:12]);
        glyph(w[11:8]);
        glyph(w[7:4]);
        glyph(w[3:0]);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_gv"}, 32'(glyph_valid), 32'd0);
        check_eq({tag, "_code"}, 32'(glyph_code), 32'd0);
        check_eq({tag, "_ge"}, 32'(glyph_err), 32'd0);
        check_eq({tag, "_wv"}, 32'(word_valid), 32'd0);
        check_eq({tag, "_word"}, 32'(word), 32'd0);
        check_eq({tag, "_match"}, 32'(match), 32'd0);
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        seg_valid = 1'b0;
        seg_in    = BLANK;
        sync_reset();

        // Writer loop, continuous seg_valid.
        wv_seen = 0;
        repeat (3) word4(EXP);
        drive(1'b0, BLANK);
        check_eq("loop_words", 32'(wv_seen), 32'd3);

        // Misaligned start.
        wv_seen = 0;
        glyph(4'h1);
        glyph(4'h0);
        word4(EXP);
        drive(1'b0, BLANK);
        check_eq("misalign_words", 32'(wv_seen), 32'd1);

        // Mismatching word.
        word4(16'hDE70);

        // Invalid pattern mid-word, then recovery.
        wv_seen = 0;
        glyph(4'hD);
        glyph(4'hE);
        drive(1'b1, BAD);
        glyph(4'h1);
        glyph(4'h0);
        check_eq("invalid_words", 32'(wv_seen), 32'd0);
        word4(EXP);

        // Repeated first glyph is data.
        word4(16'hDDE1);

        // Blanks and gaps; seg_in garbage while seg_valid is low.
        wv_seen = 0;
        glyph(4'hD);
        drive(1'b1, BLANK);
        glyph(4'hE);
        repeat (5) drive(1'b0, pat(4'h1));
        glyph(4'h1);
        drive(1'b1, BLANK);
        glyph(4'h0);
        check_eq("gap_words", 32'(wv_seen), 32'd1);

        // Async reset between edges, mid-word.
        glyph(4'hD);
        glyph(4'hE);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wv_seen = 0;
        glyph(4'h1);
        glyph(4'h0);
        check_eq("post_rst_words", 32'(wv_seen), 32'd0);
        word4(EXP);
        check_eq("post_rst_match", 32'(wv_seen), 32'd1);

`ifdef SEG7_MATCH_COUNT_EN
        sync_reset();
        check_eq("match_cnt_rst", 32'(match_cnt), 32'd0);
        check_eq("miss_cnt_rst", 32'(miss_cnt), 32'd0);
        repeat (5) word4(EXP);
        word4(16'hDE70);
        drive(1'b0, BLANK);
        check_eq("match_cnt", 32'(match_cnt), 32'd5);
        check_eq("miss_cnt", 32'(miss_cnt), 32'd1);
        check_eq("match_cnt_model", 32'(match_cnt), 32'(m_hit));
        check_eq("miss_cnt_model", 32'(miss_cnt), 32'(m_miss));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_word_reader.md
Name: seg7_word_reader

Overview:
- Receiver end of the team's 7-segment display writer.
- Samples the active-low segment bus the writer drives and decodes each pattern back to a 4-bit hex glyph.
- Aligns on the first glyph of the expected word and assembles 4-glyph words.
- Flags whether each assembled word equals the expected word ("dE10" by default).
- Used as a loopback checker on the board and as a bench monitor for display writers.

Parameters:
- EXPECT, 16'hDE10: expected word, one nibble per glyph; nibble [15:12] is displayed first.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when bit is 0 (DE10 HEX convention); 0 = lit when 1.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- seg_valid  in  1  seg_in carries a pattern this cycle
- seg_in  in  7  segment bus, bit0=a … bit6=g
- glyph_valid  out  1  one-cycle pulse: glyph_code is valid
- glyph_code  out  4  decoded hex value 0x0–0xF
- glyph_err  out  1  one-cycle pulse: undecodable pattern received
- word_valid  out  1  one-cycle pulse: word holds 4 aligned glyphs
- word  out  16  assembled word, first glyph in [15:12]
- match  out  1  qualifies word_valid: word == EXPECT

Behaviour:
- Reset: all outputs 0; FSM in HUNT; partial word cleared. Async assertion takes effect immediately, mid-word included.
- Decode: standard hex 7-seg table, after polarity normalisation.
  - Active-low examples: 0x0=1000000, 0x1=1111001, 0xD=0100001, 0xE=0000110.
  - 'b' and 'd' use lowercase forms; all other values use the usual table.
- Blank (no segments lit) is ignored: no pulse, no state change.
- Any other pattern outside the 16 entries is invalid.
- Latency: every output is registered. A sample at edge N produces its pulses at edge N+1 (visible the cycle after seg_valid).
- Glyph path: every decodable sample pulses glyph_valid with glyph_code, in every FSM state.
- Invalid sample: pulses glyph_err, discards the partial word and returns to HUNT.
- glyph_code holds its last value when glyph_valid is low.
- FSM states and transitions:
  - HUNT: a glyph equal to EXPECT[15:12] is loaded as the first nibble and goes to G1. Other glyphs are discarded; stay in HUNT.
  - G1: a glyph is appended and goes to G2.
  - G2: a glyph is appended and goes to G3.
  - G3: a glyph completes the word; go to HUNT.
  - In the same cycle as the 4th glyph_valid: word_valid=1, word=assembled value, match=(word==EXPECT).
- word holds its value until the next word_valid. match is 0 whenever word_valid is 0.
- seg_valid=0 cycles between glyphs are allowed; there is no timeout.
- Back-to-back: seg_valid may be high every cycle, and the word-completing cycle may be followed immediately by the next first glyph. Full throughput is required.
- Invalid glyph in G1–G3: glyph_err=1, no word_valid, state=HUNT. The same sample is not re-evaluated as a start glyph.
- Repeated first glyph inside a word (e.g. D,D,E,1) is treated as data, not as a resync. That input yields word=DDE1, match=0.

Optional Feature:
- Macro: SEG7_MATCH_COUNT_EN.
- Defined: adds output match_cnt [15:0], reset 0.
  - Increments on each word_valid&&match; saturates at 16'hFFFF.
  - Adds output miss_cnt [15:0] for word_valid&&!match, with the same reset and saturation rules.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package seg7_pkg:
  - segment-pattern constants for 0x0–0xF and BLANK (active-low form);
  - FSM state enum {HUNT,G1,G2,G3};
  - GLYPHS_PER_WORD=4.
  - The package is shared with the display writer.
- Sub-module seg7_glyph_decode: combinational pattern → {valid, blank, code[3:0]}. It is instantiated once here and reusable by other readers.

Test Plan:
- Writer loop: rst 3 cycles, then continuous seg_valid with 0100001, 0000110, 1111001, 1000000 repeated ×3 → three word_valid pulses, every 4th cycle, word=16'hDE10, match=1; glyph_valid on every cycle after the first.
- Misaligned start: feed 1,0,D,E,1,0 → 1 and 0 give glyph_valid only; one word_valid with word=DE10, match=1, after the 6th sample plus 1 cycle.
- Mismatch: D,E,7,0 → word_valid with word=16'hDE70, match=0.
- Invalid mid-word: D,E,7'b0110110,1,0 → glyph_err on the 3rd sample; no word_valid; FSM back in HUNT; following D,E,1,0 → match=1.
- Blank and gaps: D,blank,E,(seg_valid=0 ×5),1,blank,0 → single word_valid, DE10, match=1; no glyph_err.
- Async reset mid-word: D,E then rst pulsed between clock edges → outputs 0 immediately; subsequent 1,0 produce no word; D,E,1,0 → match=1.
- With SEG7_MATCH_COUNT_EN: run the writer loop ×5 plus one mismatch → match_cnt=5, miss_cnt=1.
